seg_scan_mux: RTL

Time-multiplexed scan driver for the 4-digit common-anode seven-segment display. It sits directly downstream of the combinational word decoder. It takes that decoder's four active-low 8-bit digit patterns (seg0..seg3) and drives one shared active-low segment bus plus four active-low digit enables, one digit at a time. Each digit slot starts with an inter-digit blanking window to suppress ghosting. Patterns are captured once per frame so a mid-frame word change never tears the display.

---
 rtl/seg_scan_mux_if.sv | 24 ++
 rtl/seg_scan_mux.sv | 112 +++++++++++
 2 files changed

// File: rtl/seg_scan_mux_if.sv
// Bundle between the word decoder/scan driver and the display pins.
// There is no handshake: en is a level and the seg inputs are sampled once per frame.
interface seg_scan_mux_if;
    logic       en;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg3;
    logic [7:0] seg_out;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_tick;
    logic [1:0] dbg_state;

    modport master (
        output en, seg0, seg1, seg2, seg3,
        input  seg_out, an, digit_idx, frame_tick, dbg_state
    );

    modport slave (
        input  en, seg0, seg1, seg2, seg3,
        output seg_out, an, digit_idx, frame_tick, dbg_state
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Four-digit common-anode scan driver with a blanking window per slot and a
// per-frame snapshot of the digit patterns so word changes never tear a frame.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave bus
);
    localparam int            CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    snap_q [4];
    logic [7:0]    snap_d [4];
    logic          load_snap;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            snap_q  <= '{default: 8'hFF};
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    // en low wins over everything, including a slot wrap on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        load_snap = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = BLANK;
                    cnt_d     = '0;
                    idx_d     = 2'd0;
                    load_snap = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CNT_DRIVE) state_d = DRIVE;
                end
                DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        idx_d     = idx_q + 2'd1;
                        state_d   = BLANK;
                        load_snap = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output registers are loaded from next-state values so they line up with state_q.
    always_comb begin
        snap_d = snap_q;
        if (load_snap) begin
            snap_d[0] = bus.seg0;
            snap_d[1] = bus.seg1;
            snap_d[2] = bus.seg2;
            snap_d[3] = bus.seg3;
        end
        an_d   = 4'hF;
        seg_d  = 8'hFF;
        tick_d = 1'b0;
        if (state_d == DRIVE) begin
            an_d   = ~(4'b0001 << idx_d);
            seg_d  = snap_d[idx_d];
            tick_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
        end
    end

    assign bus.an         = an_q;
    assign bus.seg_out    = seg_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = tick_q;
    assign bus.dbg_state  = state_q;
endmodule
